// File: rtl/adder_disp_pkg.sv
// Shared types and lookup tables for the adder sequencer and its seven-segment display.
package adder_disp_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StSettle,
      StShow
   } state_e;

   // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0-F
   localparam logic [6:0] SegTable [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   localparam logic [3:0] AnTable [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

endpackage

// File: rtl/hex_to_sseg.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex_to_sseg
   import adder_disp_pkg::*;
(
   input  logic [3:0] value_i,
   output logic [6:0] seg_o
);

   assign seg_o = SegTable[value_i];

endmodule

// File: rtl/adder_display_ctrl.sv
// Sequences operand pairs through the external 4-bit adder, captures the result and
// multiplexes A, B, carry and sum onto a 4-digit common-anode display.
module adder_display_ctrl
   import adder_disp_pkg::*;
#(
   parameter int unsigned REFRESH_DIV   = 100000,
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned HOLD_CYCLES   = 100000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [3:0] in_a,
   input  logic [3:0] in_b,
   output logic [3:0] add_a,
   output logic [3:0] add_b,
   input  logic [3:0] add_sum,
   input  logic       add_cout,
   output logic       done,
   output logic       busy,
   output logic [3:0] an,
   output logic [6:0] seg
);

   localparam int unsigned SetW  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam int unsigned RefW  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

   state_e            state_q;
   logic [SetW-1:0]   settle_q;
   logic [HoldW-1:0]  hold_q;
   logic [3:0]        res_a_q;
   logic [3:0]        res_b_q;
   logic [3:0]        res_sum_q;
   logic              res_cout_q;

   assign in_ready = (state_q != StSettle);
   assign busy     = (state_q == StSettle);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         settle_q   <= '0;
         hold_q     <= '0;
         add_a      <= '0;
         add_b      <= '0;
         done       <= 1'b0;
         res_a_q    <= '0;
         res_b_q    <= '0;
         res_sum_q  <= '0;
         res_cout_q <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (in_valid) begin
                  add_a    <= in_a;
                  add_b    <= in_b;
                  settle_q <= '0;
                  state_q  <= StSettle;
               end
            end
            StSettle: begin
               if (settle_q == SetW'(SETTLE_CYCLES - 1)) begin
                  res_sum_q  <= add_sum;
                  res_cout_q <= add_cout;
                  res_a_q    <= add_a;
                  res_b_q    <= add_b;
                  done       <= 1'b1;
                  hold_q     <= '0;
                  state_q    <= StShow;
               end else begin
                  settle_q <= settle_q + SetW'(1);
               end
            end
            StShow: begin
               // A new pair wins over hold expiry on the same edge
               if (in_valid) begin
                  add_a    <= in_a;
                  add_b    <= in_b;
                  settle_q <= '0;
                  state_q  <= StSettle;
               end else if (hold_q == HoldW'(HOLD_CYCLES - 1)) begin
                  state_q <= StIdle;
               end else begin
                  hold_q <= hold_q + HoldW'(1);
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   logic [RefW-1:0] refresh_q;
   logic [1:0]      digit_q;
   logic [1:0]      digit_d;
   logic            refresh_wrap;
   logic [3:0]      nibble;
   logic [6:0]      seg_d;

   assign refresh_wrap = (refresh_q == RefW'(REFRESH_DIV - 1));

   // Select from the next digit index so an and seg change together
   always_comb begin
      digit_d = digit_q;
      if (refresh_wrap) begin
         digit_d = digit_q + 2'd1;
      end
      nibble = res_a_q;
      unique case (digit_d)
         2'd0:    nibble = res_sum_q;
         2'd1:    nibble = {3'b000, res_cout_q};
         2'd2:    nibble = res_b_q;
         default: nibble = res_a_q;
      endcase
   end

   hex_to_sseg u_hex_to_sseg (
      .value_i (nibble),
      .seg_o   (seg_d)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         refresh_q <= '0;
         digit_q   <= 2'd0;
         an        <= AnTable[0];
         seg       <= SegTable[0];
      end else begin
         refresh_q <= refresh_wrap ? '0 : refresh_q + RefW'(1);
         digit_q   <= digit_d;
         an        <= AnTable[digit_d];
         seg       <= seg_d;
      end
   end

endmodule
